// File: rtl/bus_timer.sv
// -----------------------------------------------------------------------------
// bus_timer
//
// Memory-mapped countdown timer on the responder side of the CPU data port.
// Decodes a 16-byte register window at BASE_ADDR:
//   +0x0 CTRL   [0] EN, [2:1] MODE (00 one-shot, 01 auto-reload), [3] IM
//   +0x4 PRESET 32-bit read/write reload value
//   +0x8 COUNT  32-bit read-only down-counter
//   +0xC reserved (reads 0, writes ignored)
// Counts down from PRESET and raises a level interrupt (irq = IM & IRQF).
//
// Ports:
//   clk     in   1  rising-edge clock
//   reset   in   1  asynchronous reset, active low
//   addr    in  32  CPU data address
//   byteen  in   4  per-lane write enables (all zero = no write)
//   wdata   in  32  lane-aligned write data
//   rdata   out 32  combinational read data (0 on address miss)
//   irq     out  1  level interrupt request to HWInt
//
// Configuration macro: BUS_TIMER_AUTORELOAD_EN
//   defined   : MODE 01 reloads PRESET after each expiry
//   undefined : MODE bits are not stored, read as 0, every mode is one-shot
// -----------------------------------------------------------------------------
module bus_timer #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [3:0]  byteen,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CNT  = 2'd2,
        INT  = 2'd3
    } state_t;

    localparam logic [1:0] SEL_CTRL   = 2'd0;
    localparam logic [1:0] SEL_PRESET = 2'd1;
    localparam logic [1:0] SEL_COUNT  = 2'd2;

`ifdef BUS_TIMER_AUTORELOAD_EN
    localparam logic [3:0] CTRL_MASK = 4'b1111;
`else
    // MODE bits are simply never stored, so they read back as 0.
    localparam logic [3:0] CTRL_MASK = 4'b1001;
`endif

    state_t      state_q;
    logic [3:0]  ctrl_q;
    logic [31:0] preset_q;
    logic [31:0] count_q;
    logic        irqf_q;

    logic        hit;
    logic [1:0]  sel;
    logic        wr_any;
    logic        wr_ctrl;
    logic        wr_preset;
    logic [3:0]  ctrl_d;
    logic [31:0] preset_d;
    logic        reload;
    logic        expire;
    logic        unused_addr_lo;

    // Byte-lane merge of a CPU write into an existing 32-bit register.
    function automatic logic [31:0] lane_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  be);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_val[8*i +: 8];
            end
        end
        return res;
    endfunction

    assign hit       = (addr[31:4] == BASE_ADDR[31:4]);
    assign sel       = addr[3:2];
    assign wr_any    = |byteen;
    assign wr_ctrl   = hit && (sel == SEL_CTRL)   && wr_any;
    assign wr_preset = hit && (sel == SEL_PRESET) && wr_any;
    assign unused_addr_lo = ^addr[1:0];

    // CTRL only has bits in lane 0; the upper lanes carry nothing to store.
    assign ctrl_d   = (byteen[0] ? wdata[3:0] : ctrl_q) & CTRL_MASK;
    assign preset_d = lane_merge(preset_q, wdata, byteen);

`ifdef BUS_TIMER_AUTORELOAD_EN
    assign reload = (ctrl_q[2:1] == 2'b01);
`else
    assign reload = 1'b0;
`endif

    // Final CNT cycle: enabled and COUNT at 1 or 0 (PRESET=0 acts like 1).
    assign expire = (state_q == CNT) && ctrl_q[0] && (count_q <= 32'd1);

    always_comb begin
        rdata = 32'd0;
        if (hit) begin
            case (sel)
                SEL_CTRL:   rdata = {28'd0, ctrl_q};
                SEL_PRESET: rdata = preset_q;
                SEL_COUNT:  rdata = count_q;
                default:    rdata = 32'd0;
            endcase
        end
    end

    assign irq = ctrl_q[3] & irqf_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            ctrl_q   <= 4'd0;
            preset_q <= 32'd0;
            count_q  <= 32'd0;
            irqf_q   <= 1'b0;
        end else begin
            // A CPU write to CTRL takes priority over the one-shot EN clear.
            if (wr_ctrl) begin
                ctrl_q <= ctrl_d;
            end else if ((state_q == INT) && !reload) begin
                ctrl_q[0] <= 1'b0;
            end

            if (wr_preset) begin
                preset_q <= preset_d;
            end

            // Register writes clear IRQF even when expiry happens on the same edge.
            if (wr_ctrl || wr_preset) begin
                irqf_q <= 1'b0;
            end else if (expire) begin
                irqf_q <= 1'b1;
            end else if ((state_q == LOAD) || ((state_q == INT) && reload)) begin
                irqf_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (ctrl_q[0]) begin
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    count_q <= preset_q;
                    state_q <= CNT;
                end
                CNT: begin
                    if (!ctrl_q[0]) begin
                        state_q <= IDLE;
                    end else if (count_q > 32'd1) begin
                        count_q <= count_q - 32'd1;
                    end else begin
                        count_q <= 32'd0;
                        state_q <= INT;
                    end
                end
                INT: begin
                    state_q <= reload ? LOAD : IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_timer.sv
// -----------------------------------------------------------------------------
// tb_bus_timer
//
// Directed bench for bus_timer. Stimulus tasks push the hand-computed expected
// value of each read or irq observation into a scoreboard queue and raise an
// event; an independent monitor process pops and compares.
// -----------------------------------------------------------------------------
module tb_bus_timer;

    localparam logic [31:0] BASE   = 32'h0000_7F00;
    localparam logic [31:0] A_CTRL = BASE;
    localparam logic [31:0] A_PRE  = BASE + 32'd4;
    localparam logic [31:0] A_CNT  = BASE + 32'd8;
    localparam logic [31:0] A_RSV  = BASE + 32'd12;
    localparam logic [31:0] A_MISS = BASE + 32'd16;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr;
    logic [3:0]  byteen;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    always #5 clk = ~clk;

    bus_timer #(.BASE_ADDR(BASE)) dut (
        .clk    (clk),
        .reset  (reset),
        .addr   (addr),
        .byteen (byteen),
        .wdata  (wdata),
        .rdata  (rdata),
        .irq    (irq)
    );

    typedef struct {
        logic [31:0] exp;
        bit          is_irq;
        string       name;
    } exp_t;

    exp_t sb[$];
    event chk_ev;
    int   n_chk  = 0;
    int   n_fail = 0;

    // Monitor: compares DUT output against the oldest queued expectation.
    initial begin : monitor
        exp_t        e;
        logic [31:0] act;
        forever begin
            @(chk_ev);
            n_chk++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL sb_underflow: observation with no expected entry");
            end else begin
                e   = sb.pop_front();
                act = e.is_irq ? {31'd0, irq} : rdata;
                if (act !== e.exp) begin
                    n_fail++;
                    $display("FAIL %s: got 32'h%08h, expected 32'h%08h", e.name, act, e.exp);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Write lands on the next rising edge; returns 1 ns after it.
    task automatic wr(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
        addr   = a;
        byteen = be;
        wdata  = d;
        @(posedge clk);
        #1;
        byteen = 4'd0;
        wdata  = 32'd0;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string nm);
        exp_t e;
        byteen = 4'd0;
        addr   = a;
        #1;
        e.exp = exp; e.is_irq = 1'b0; e.name = nm;
        sb.push_back(e);
        ->chk_ev;
        #1;
    endtask

    task automatic chk_irq(input logic exp, input string nm);
        exp_t e;
        #1;
        e.exp = {31'd0, exp}; e.is_irq = 1'b1; e.name = nm;
        sb.push_back(e);
        ->chk_ev;
        #1;
    endtask

`ifdef BUS_TIMER_AUTORELOAD_EN
    localparam logic [31:0] AR_CTRL_RB = 32'h0000_000B;
    logic [31:0] ar_cnt [2:10] = '{32'd3, 32'd2, 32'd1, 32'd0, 32'd0, 32'd3, 32'd2, 32'd1, 32'd0};
    logic        ar_irq [2:10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
`else
    localparam logic [31:0] AR_CTRL_RB = 32'h0000_0009;
    logic [31:0] ar_cnt [2:10] = '{32'd3, 32'd2, 32'd1, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    logic        ar_irq [2:10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
`endif

    initial begin : stim
        exp_t e;
        reset  = 1'b0;
        addr   = A_CTRL;
        byteen = 4'd0;
        wdata  = 32'd0;

        // Reset then read
        step(3);
        reset = 1'b1;
        step(1);
        rd(A_CTRL, 32'd0, "rst_ctrl");
        rd(A_PRE,  32'd0, "rst_preset");
        rd(A_CNT,  32'd0, "rst_count");
        chk_irq(1'b0, "rst_irq");
        step(1);

        // One-shot, PRESET=5, IM=1
        wr(A_PRE, 4'hF, 32'd5);
        wr(A_CTRL, 4'hF, 32'h9);                 // E0
        rd(A_CTRL, 32'h9, "os_ctrl_rb");
        step(2);                                 // E2
        rd(A_CNT, 32'd5, "os_count_e2");
        chk_irq(1'b0, "os_irq_e2");
        step(4);                                 // E6
        rd(A_CNT, 32'd1, "os_count_e6");
        chk_irq(1'b0, "os_irq_e6");
        step(1);                                 // E7
        rd(A_CNT, 32'd0, "os_count_e7");
        chk_irq(1'b1, "os_irq_e7");
        step(3);                                 // E10
        chk_irq(1'b1, "os_irq_held");
        rd(A_CTRL, 32'h8, "os_en_cleared");
        wr(A_CTRL, 4'hF, 32'h0);
        chk_irq(1'b0, "os_irq_cleared");
        rd(A_CTRL, 32'h0, "os_ctrl_zero");

        // PRESET=0 behaves like PRESET=1; PRESET write clears IRQF
        wr(A_PRE, 4'hF, 32'd0);
        wr(A_CTRL, 4'hF, 32'h9);                 // E0
        step(2);                                 // E2
        rd(A_CNT, 32'd0, "p0_count_e2");
        chk_irq(1'b0, "p0_irq_e2");
        step(1);                                 // E3
        chk_irq(1'b1, "p0_irq_e3");
        step(1);
        rd(A_CTRL, 32'h8, "p0_en_cleared");
        wr(A_PRE, 4'hF, 32'd7);
        chk_irq(1'b0, "p0_preset_wr_clears");
        rd(A_PRE, 32'd7, "p0_preset_rb");

        // CPU CTRL write in INT wins over the EN clear
        wr(A_PRE, 4'hF, 32'd1);
        wr(A_CTRL, 4'hF, 32'h9);                 // E0
        step(2);                                 // E2
        rd(A_CNT, 32'd1, "win_count_e2");
        step(1);                                 // E3 INT
        chk_irq(1'b1, "win_irq_e3");
        wr(A_CTRL, 4'hF, 32'h9);                 // E4
        chk_irq(1'b0, "win_irq_e4");
        rd(A_CTRL, 32'h9, "win_en_kept");
        step(2);                                 // E6
        rd(A_CNT, 32'd1, "win_count_e6");
        chk_irq(1'b0, "win_irq_e6");
        step(1);                                 // E7
        chk_irq(1'b1, "win_irq_e7");
        wr(A_CTRL, 4'hF, 32'h0);
        step(2);
        rd(A_CTRL, 32'h0, "win_stopped");

        // MODE 01 (auto-reload when enabled, one-shot otherwise), PRESET=3
        wr(A_PRE, 4'hF, 32'd3);
        wr(A_CTRL, 4'hF, 32'hB);                 // E0
        rd(A_CTRL, AR_CTRL_RB, "ar_ctrl_rb");
        step(1);                                 // E1
        for (int k = 2; k <= 10; k++) begin
            step(1);
            rd(A_CNT, ar_cnt[k], $sformatf("ar_count_e%0d", k));
            chk_irq(ar_irq[k], $sformatf("ar_irq_e%0d", k));
        end
        wr(A_CTRL, 4'hF, 32'h0);
        step(4);
        chk_irq(1'b0, "ar_stopped_irq");

        // Byte enables, read-only COUNT, reserved slot
        wr(A_PRE, 4'hF, 32'd0);
        wr(A_PRE, 4'b0101, 32'hAABBCCDD);
        rd(A_PRE, 32'h00BB00DD, "be_preset");
        wr(A_CTRL, 4'b1110, 32'hFFFFFFFF);
        rd(A_CTRL, 32'h0, "be_ctrl_upper_lanes");
        wr(A_RSV, 4'hF, 32'hFFFFFFFF);
        rd(A_RSV, 32'h0, "rsv_reads_zero");

        // Disable mid-count, PRESET=100
        wr(A_PRE, 4'hF, 32'd100);
        wr(A_CTRL, 4'hF, 32'h9);                 // E0
        step(52);                                // E52
        rd(A_CNT, 32'd50, "dis_count_50");
        wr(A_CTRL, 4'hF, 32'h8);                 // E53, in-flight decrement
        rd(A_CNT, 32'd49, "dis_count_e53");
        step(3);
        rd(A_CNT, 32'd49, "dis_count_hold");
        chk_irq(1'b0, "dis_irq");
        rd(A_CTRL, 32'h8, "dis_ctrl");
        wr(A_CNT, 4'hF, 32'hFFFFFFFF);
        rd(A_CNT, 32'd49, "count_ro");
        step(5);
        rd(A_CNT, 32'd49, "dis_count_hold2");

        // Asynchronous reset between clock edges
        reset = 1'b0;
        #1;
        rd(A_CNT,  32'd0, "async_rst_count");
        rd(A_PRE,  32'd0, "async_rst_preset");
        rd(A_CTRL, 32'd0, "async_rst_ctrl");
        step(2);
        reset = 1'b1;
        step(1);

        // Address miss
        wr(A_PRE, 4'hF, 32'd2);
        wr(A_MISS, 4'hF, 32'hFFFFFFFF);
        rd(A_CTRL, 32'h0, "miss_ctrl_untouched");
        rd(A_MISS + 32'd4, 32'h0, "miss_read_zero");
        wr(A_MISS + 32'd4, 4'hF, 32'h0);
        rd(A_PRE, 32'd2, "miss_preset_untouched");

        // IM=0 hides IRQF; partial CTRL write setting IM also clears IRQF
        wr(A_CTRL, 4'hF, 32'h1);                 // E0, INT at E4
        step(6);
        chk_irq(1'b0, "mask_irq_low");
        rd(A_CNT, 32'd0, "mask_count");
        rd(A_CTRL, 32'h0, "mask_en_cleared");
        wr(A_CTRL, 4'b0001, 32'h8);
        chk_irq(1'b0, "mask_im_set_irq");
        rd(A_CTRL, 32'h8, "mask_ctrl_rb");
        step(3);
        chk_irq(1'b0, "mask_irq_stays_low");

        // Every expectation must have been consumed by the monitor
        step(1);
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: %0d entries left, expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
